// File: rtl/pe3_inv_bf.sv
// Inverse-NTT (Gentleman-Sande) butterfly, q = 3329, constant twiddle W_INV, 7-stage pipeline.
// Define PE3_INV_HALVE_EN to halve both outputs mod Q in the last stage.
module pe3_inv_bf #(
  parameter int unsigned data_width = 12,
  parameter int unsigned Q          = 3329,
  parameter int unsigned W_INV      = 754,
  parameter int unsigned MUL_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [data_width-1:0] u,
  input  logic [data_width-1:0] v,
  output logic                  out_valid,
  output logic [data_width-1:0] bf_upper,
  output logic [data_width-1:0] bf_lower,
  output logic                  busy
);

  localparam int unsigned W   = data_width;
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned MW  = W + 1;
  localparam int unsigned RW  = W + 2;
  localparam int unsigned BK  = PW;
  localparam int unsigned BM  = (32'd1 << BK) / Q;
  localparam int unsigned NST = 3 + MUL_STAGES;

  localparam logic [W:0]       QX  = (W + 1)'(Q);
  localparam logic [PW-1:0]    QP  = PW'(Q);
  localparam logic [RW-1:0]    QR  = RW'(Q);
  localparam logic [PW-1:0]    WP  = PW'(W_INV);
  localparam logic [PW+MW-1:0] BMX = (PW + MW)'(BM);

  logic [NST-1:0] vld_q, vld_d;
  logic [W-1:0]   u_q, u_d, v_q, v_d;
  logic [W-1:0]   a1_q, a1_d, d1_q, d1_d;
  logic [W-1:0]   a2_q, a2_d, a3_q, a3_d, a4_q, a4_d, a5_q, a5_d;
  logic [PW-1:0]  p2_q, p2_d, p3_q, p3_d;
  logic [MW-1:0]  qh3_q, qh3_d;
  logic [RW-1:0]  r4_q, r4_d;
  logic [W-1:0]   m5_q, m5_d;
  logic [W-1:0]   up6_q, up6_d, lo6_q, lo6_d;

  logic [W:0]       sum, dif;
  logic [PW+MW-1:0] qprod;
  logic [PW-1:0]    qq;
  logic [RW-1:0]    r_s1;

`ifdef PE3_INV_HALVE_EN
  function automatic logic [W-1:0] halve(input logic [W-1:0] x);
    logic [W:0] t;
    t = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
    return W'(t >> 1);
  endfunction
`endif

  always_comb begin
    vld_d = {vld_q[NST-2:0], in_valid};
    u_d   = u;
    v_d   = v;

    sum   = {1'b0, u_q} + {1'b0, v_q};
    a1_d  = (sum >= QX) ? W'(sum - QX) : W'(sum);
    dif   = (u_q >= v_q) ? ({1'b0, u_q} - {1'b0, v_q})
                         : ({1'b0, u_q} + QX - {1'b0, v_q});
    d1_d  = W'(dif);

    // Barrett reduction of d*W_INV: quotient estimate is low by at most 2, so r < 3Q
    p2_d  = PW'(d1_q) * WP;
    a2_d  = a1_q;

    qprod = (PW + MW)'(p2_q) * BMX;
    qh3_d = MW'(qprod >> BK);
    p3_d  = p2_q;
    a3_d  = a2_q;

    qq    = PW'(qh3_q) * QP;
    r4_d  = RW'(p3_q - qq);
    a4_d  = a3_q;

    r_s1  = (r4_q >= QR) ? (r4_q - QR) : r4_q;
    m5_d  = (r_s1 >= QR) ? W'(r_s1 - QR) : W'(r_s1);
    a5_d  = a4_q;

`ifdef PE3_INV_HALVE_EN
    up6_d = halve(a5_q);
    lo6_d = halve(m5_q);
`else
    up6_d = a5_q;
    lo6_d = m5_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      u_q   <= '0;
      v_q   <= '0;
      a1_q  <= '0;
      d1_q  <= '0;
      a2_q  <= '0;
      p2_q  <= '0;
      a3_q  <= '0;
      p3_q  <= '0;
      qh3_q <= '0;
      a4_q  <= '0;
      r4_q  <= '0;
      a5_q  <= '0;
      m5_q  <= '0;
      up6_q <= '0;
      lo6_q <= '0;
    end else if (en) begin
      vld_q <= vld_d;
      u_q   <= u_d;
      v_q   <= v_d;
      a1_q  <= a1_d;
      d1_q  <= d1_d;
      a2_q  <= a2_d;
      p2_q  <= p2_d;
      a3_q  <= a3_d;
      p3_q  <= p3_d;
      qh3_q <= qh3_d;
      a4_q  <= a4_d;
      r4_q  <= r4_d;
      a5_q  <= a5_d;
      m5_q  <= m5_d;
      up6_q <= up6_d;
      lo6_q <= lo6_d;
    end
  end

  assign out_valid = vld_q[NST-1];
  assign bf_upper  = up6_q;
  assign bf_lower  = lo6_q;
  assign busy      = |vld_q;

endmodule

// File: tb/tb_pe3_inv_bf.sv
// Scoreboard bench for pe3_inv_bf; honours PE3_INV_HALVE_EN for expected values.
module tb_pe3_inv_bf;

  localparam int unsigned W    = 12;
  localparam int unsigned Q    = 3329;
  localparam int unsigned WINV = 754;
  localparam int unsigned WFWD = 3095;
  localparam int unsigned HALF = 1665;

`ifdef PE3_INV_HALVE_EN
  localparam int unsigned E1U = 1671, E1L = 2639;
  localparam int unsigned E2U = 1665, E2L = 2952;
  localparam int unsigned E3U = 3328, E3L = 0;
  localparam int unsigned E4U = 100,  E4L = 200;
  localparam int unsigned E5U = 500,  E5L = 0;
`else
  localparam int unsigned E1U = 13,   E1L = 1949;
  localparam int unsigned E2U = 1,    E2L = 2575;
  localparam int unsigned E3U = 3327, E3L = 0;
  localparam int unsigned E4U = 200,  E4L = 400;
  localparam int unsigned E5U = 1000, E5L = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] u = '0;
  logic [W-1:0] v = '0;
  logic         out_valid, busy;
  logic [W-1:0] bf_upper, bf_lower;

  typedef struct {
    int unsigned up;
    int unsigned lo;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pe3_inv_bf #(.data_width(W), .Q(Q), .W_INV(WINV), .MUL_STAGES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .u        (u),
    .v        (v),
    .out_valid(out_valid),
    .bf_upper (bf_upper),
    .bf_lower (bf_lower),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned a, input int unsigned b);
    exp_t e;
    e.up = (a + b) % Q;
    e.lo = (((a + Q - b) % Q) * WINV) % Q;
`ifdef PE3_INV_HALVE_EN
    e.up = (e.up * HALF) % Q;
    e.lo = (e.lo * HALF) % Q;
`endif
    return e;
  endfunction

  always @(posedge clk)
    if (rst && en && in_valid)
      assert (u < Q && v < Q) else $error("operand out of range u=%0d v=%0d", u, v);

  // A result is consumed on the next enabled edge; en here is what that edge will see.
  always @(negedge clk) begin
    if (rst && out_valid && en) begin
      check("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("upper", bf_upper, e.up);
        check("lower", bf_lower, e.lo);
      end
      check("busy_with_ov", busy, 1);
    end
  end

  task automatic drive_e(input logic vld, input int unsigned a, input int unsigned b, input exp_t e);
    in_valid = vld;
    u = W'(a);
    v = W'(b);
    if (vld && en) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input int unsigned a, input int unsigned b);
    drive_e(vld, a, b, model(a, b));
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check({tag, "_drained"}, sb.size(), 0);
    check({tag, "_ov_after"}, out_valid, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic single(input string tag, input int unsigned a, input int unsigned b,
                        input int unsigned eu, input int unsigned el);
    int unsigned cnt;
    cnt = 0;
    en = 1'b1;
    in_valid = 1'b1;
    u = W'(a);
    v = W'(b);
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (out_valid) break;
    end
    check({tag, "_lat"}, cnt, 7);
    check({tag, "_up"}, bf_upper, eu);
    check({tag, "_lo"}, bf_lower, el);
    @(negedge clk);
    check({tag, "_ov_1cyc"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #11;
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_up", bf_upper, 0);
    check("rst_lo", bf_lower, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;

    single("t_10_3", 10, 3, E1U, E1L);
    single("t_0_1", 0, 1, E2U, E2L);
    single("t_max", 3328, 3328, E3U, E3L);
    single("t_rt", 3235, 294, E4U, E4L);
    single("t_ueqv", 500, 500, E5U, E5L);

    // Ten pairs with a three-cycle hold after the fourth; inputs during hold must be ignored
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i * 337 + 11) % Q, (i * 911 + 5) % Q);
      if (i == 3) begin
        logic [W-1:0] su, sl;
        en = 1'b0;
        in_valid = 1'b1;
        u = W'(1234);
        v = W'(4);
        @(negedge clk);
        su = bf_upper;
        sl = bf_lower;
        for (int h = 0; h < 3; h++) begin
          @(posedge clk);
          #1;
          check("hold_ov", out_valid, 0);
          check("hold_busy", busy, 1);
          check("hold_up", bf_upper, su);
          check("hold_lo", bf_lower, sl);
          if (h == 2) en = 1'b1;
        end
      end
    end
    drain("hold");

    // Forward CT pair fed back through the inverse must recover (x, y), scaled by 2 when unhalved
    for (int i = 0; i < 64; i++) begin
      int unsigned x, y, t, fu, fl;
      exp_t e;
      x  = $urandom_range(Q - 1);
      y  = $urandom_range(Q - 1);
      t  = (WFWD * y) % Q;
      fu = (x + t) % Q;
      fl = (x + Q - t) % Q;
`ifdef PE3_INV_HALVE_EN
      e.up = x;
      e.lo = y;
`else
      e.up = (2 * x) % Q;
      e.lo = (2 * y) % Q;
`endif
      drive_e(1'b1, fu, fl, e);
    end
    drain("rt_stream");

    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(3) != 0);
      drive($urandom_range(4) != 0, $urandom_range(Q - 1), $urandom_range(Q - 1));
    end
    drain("rand_en");

    for (int i = 0; i < 8; i++) drive(1'b1, (i * 101 + 7) % Q, (i * 53 + 3000) % Q);
    check("pre_rst_ov", out_valid, 1);
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    check("midrst_ov", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_up", bf_upper, 0);
    check("midrst_lo", bf_lower, 0);
    @(posedge clk);
    #1;
    check("midrst_hold_busy", busy, 0);
    rst = 1'b1;
    single("post_rst", 10, 3, E1U, E1L);
    drain("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
